// File: rtl/prio_dec_pkg.sv
// Shared types and helpers for the priority-code decoder.
package prio_dec_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Counter width large enough for both the hold and the gap reload values.
  function automatic int cnt_w(input int hold, input int gap);
    int hw;
    int gw;
    hw = (hold > 1) ? $clog2(hold) : 1;
    gw = (gap > 1) ? $clog2(gap) : 1;
    return (hw > gw) ? hw : gw;
  endfunction

endpackage

// File: rtl/prio_dec_timer.sv
// Loadable down-counter with terminal-count flag; holds at zero.
module prio_dec_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/prio_code_decoder.sv
// Binary code to timed one-hot pulse with hold and guard gap.
// Optional err output and sticky flag enabled by PRIO_DEC_ERR_EN.
module prio_code_decoder
  import prio_dec_pkg::*;
#(
  parameter  int OUT_W       = 4,
  parameter  int HOLD_CYCLES = 4,
  parameter  int GAP_CYCLES  = 1,
  localparam int CODE_W      = $clog2(OUT_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              code_valid,
  input  logic [CODE_W-1:0] code,
  output logic              code_ready,
  input  logic              flush,
  output logic [OUT_W-1:0]  dout,
  output logic              dout_valid,
  output logic              busy
`ifdef PRIO_DEC_ERR_EN
  , output logic            err
`endif
);

  localparam int            CW      = cnt_w(HOLD_CYCLES, GAP_CYCLES);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD  = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
  localparam logic [CODE_W:0] OUT_W_V = (CODE_W + 1)'(OUT_W);

  state_t            state;
  logic              accept;
  logic              in_range;
  logic              start;
  logic              to_gap;
  logic              t_load;
  logic [CW-1:0]     t_load_val;
  logic              t_zero;
  logic [OUT_W-1:0]  onehot;

  assign accept   = code_valid & code_ready;
  // Zero-extend so the compare also works when OUT_W is not a power of 2.
  assign in_range = ({1'b0, code} < OUT_W_V);
  assign onehot   = {{(OUT_W-1){1'b0}}, 1'b1} << code;

  assign start      = !flush && (state == IDLE) && accept && in_range;
  assign to_gap     = !flush && (state == DRIVE) && t_zero && (GAP_CYCLES > 0);
  assign t_load     = start | to_gap;
  assign t_load_val = start ? HOLD_LD : GAP_LD;

  prio_dec_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (flush),
    .load     (t_load),
    .load_val (t_load_val),
    .zero     (t_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dout       <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      code_ready <= 1'b0;
    end else if (flush) begin
      state      <= IDLE;
      dout       <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      code_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          code_ready <= 1'b1;
          if (accept && in_range) begin
            state      <= DRIVE;
            dout       <= onehot;
            dout_valid <= 1'b1;
            busy       <= 1'b1;
            code_ready <= 1'b0;
          end
        end
        DRIVE: begin
          if (t_zero) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            if (GAP_CYCLES > 0) begin
              state <= GAP;
            end else begin
              state      <= IDLE;
              busy       <= 1'b0;
              code_ready <= 1'b1;
            end
          end
        end
        GAP: begin
          if (t_zero) begin
            state      <= IDLE;
            busy       <= 1'b0;
            code_ready <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          dout       <= '0;
          dout_valid <= 1'b0;
          busy       <= 1'b0;
          code_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef PRIO_DEC_ERR_EN
  logic oor;
  logic err_sticky;

  assign oor = accept & ~in_range;

  // err is the one-cycle pulse OR the sticky flag, kept as one register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
      err        <= 1'b0;
    end else if (flush) begin
      err_sticky <= 1'b0;
      err        <= 1'b0;
    end else begin
      err_sticky <= err_sticky | oor;
      err        <= err_sticky | oor;
    end
  end
`endif

endmodule

// File: tb/tb_prio_code_decoder.sv
// Directed self-checking bench: default 4-line instance plus a 5-line, no-gap instance.
module tb_prio_code_decoder;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       code_valid, flush;
  logic [1:0] code;
  logic       code_ready, dout_valid, busy;
  logic [3:0] dout;

  logic       v5, f5;
  logic [2:0] c5;
  logic       ready5, dv5, busy5;
  logic [4:0] dout5;

  int n_chk  = 0;
  int n_fail = 0;
  int hit;

`ifdef PRIO_DEC_ERR_EN
  logic err, err5;
`endif

  always #5 clk = ~clk;

  prio_code_decoder #(.OUT_W(4), .HOLD_CYCLES(4), .GAP_CYCLES(1)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .code_valid (code_valid),
    .code       (code),
    .code_ready (code_ready),
    .flush      (flush),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy)
`ifdef PRIO_DEC_ERR_EN
    , .err      (err)
`endif
  );

  prio_code_decoder #(.OUT_W(5), .HOLD_CYCLES(2), .GAP_CYCLES(0)) u_dut5 (
    .clk        (clk),
    .rst_n      (rst_n),
    .code_valid (v5),
    .code       (c5),
    .code_ready (ready5),
    .flush      (f5),
    .dout       (dout5),
    .dout_valid (dv5),
    .busy       (busy5)
`ifdef PRIO_DEC_ERR_EN
    , .err      (err5)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (code_ready) break;
      step();
    end
    chk("wait_ready", code_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; code_valid = 1'b0; code = '0; flush = 1'b0;
    v5 = 1'b0; c5 = '0; f5 = 1'b0;

    // 1: reset state, then ready one clock after release
    step(); step();
    chk("rst_dout", dout, 4'b0000);
    chk("rst_dv", dout_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", code_ready, 0);
    rst_n = 1'b1;
    chk("rel_ready_0", code_ready, 0);
    step();
    chk("rel_ready_1", code_ready, 1);

    // 2: single code 2, hold T1..T4, gap T5, ready T6
    code_valid = 1'b1; code = 2'd2;
    step();
    code_valid = 1'b0;
    chk("t2_dout_T1", dout, 4'b0100);
    chk("t2_dv_T1", dout_valid, 1);
    chk("t2_busy_T1", busy, 1);
    chk("t2_ready_T1", code_ready, 0);
    for (int i = 2; i <= 4; i++) begin
      step();
      chk("t2_dout_hold", dout, 4'b0100);
    end
    step();
    chk("t2_dout_T5", dout, 4'b0000);
    chk("t2_dv_T5", dout_valid, 0);
    chk("t2_busy_T5", busy, 1);
    chk("t2_ready_T5", code_ready, 0);
    step();
    chk("t2_ready_T6", code_ready, 1);
    chk("t2_busy_T6", busy, 0);

    // 3: valid held, code 3 then 0; 0001 exactly 6 cycles after first 1000
    code_valid = 1'b1; code = 2'd3;
    step();
    chk("t3_first", dout, 4'b1000);
    code = 2'd0;
    hit = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i <= 3) chk("t3_hold", dout, 4'b1000);
      if (i == 4 || i == 5) chk("t3_gap", dout, 4'b0000);
      if (dout == 4'b0001 && hit == 0) hit = i;
    end
    chk("t3_period", hit, 6);
    code_valid = 1'b0;
    wait_ready(20);

    // 4: flush in the 2nd DRIVE cycle; flush+accept in IDLE
    code_valid = 1'b1; code = 2'd1;
    step();
    code_valid = 1'b0;
    chk("t4_dout_T1", dout, 4'b0010);
    step();
    chk("t4_dout_T2", dout, 4'b0010);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t4_fl_dout", dout, 4'b0000);
    chk("t4_fl_dv", dout_valid, 0);
    chk("t4_fl_busy", busy, 0);
    chk("t4_fl_ready", code_ready, 1);
    flush = 1'b1; code_valid = 1'b1; code = 2'd3;
    step();
    flush = 1'b0; code_valid = 1'b0;
    chk("t4_fa_dout", dout, 4'b0000);
    chk("t4_fa_ready", code_ready, 1);
    step();
    chk("t4_fa_dout2", dout, 4'b0000);
    chk("t4_fa_busy", busy, 0);

    // 5: out-of-range code on 5-line instance, then top line with no gap
    v5 = 1'b1; c5 = 3'd6;
    step();
    v5 = 1'b0;
    chk("t5_oor_dout", dout5, 5'b00000);
    chk("t5_oor_ready", ready5, 1);
    chk("t5_oor_busy", busy5, 0);
`ifdef PRIO_DEC_ERR_EN
    chk("t5_err_pulse", err5, 1);
`endif
    step();
    chk("t5_oor_dout2", dout5, 5'b00000);
`ifdef PRIO_DEC_ERR_EN
    chk("t5_err_sticky", err5, 1);
`endif
    v5 = 1'b1; c5 = 3'd4;
    step();
    v5 = 1'b0;
    chk("t5_top_T1", dout5, 5'b10000);
    chk("t5_dv_T1", dv5, 1);
    step();
    chk("t5_top_T2", dout5, 5'b10000);
    step();
    chk("t5_end_dout", dout5, 5'b00000);
    chk("t5_end_ready", ready5, 1);
    chk("t5_end_busy", busy5, 0);
    f5 = 1'b1;
    step();
    f5 = 1'b0;
`ifdef PRIO_DEC_ERR_EN
    chk("t5_err_clr", err5, 0);
`endif
    chk("t5_fl_ready", ready5, 1);

    // 6: async reset mid-DRIVE clears outputs before next edge
    code_valid = 1'b1; code = 2'd1;
    step();
    code_valid = 1'b0;
    chk("t6_dout_T1", dout, 4'b0010);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_dout", dout, 4'b0000);
    chk("t6_rst_dv", dout_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_ready", code_ready, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("t6_rel_ready", code_ready, 1);
    chk("t6_rel_dout", dout, 4'b0000);
    chk("t6_rel_busy", busy, 0);
    code_valid = 1'b1; code = 2'd0;
    step();
    code_valid = 1'b0;
    chk("t6_resume", dout, 4'b0001);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
